stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
- Control FSM for the stopwatch's cascaded BCD digit-counter chain.
- Turns the start/stop, clear and lap buttons plus a timebase tick into counter-chain controls: count enable, direction, clear and preset load.
- Detects the terminal count (all digits at max when counting up, all digits zero when counting down) and stops the chain there instead of letting it wrap.
- Sits between the button/timebase logic and the digit counters; the per-digit carry/borrow logic stays inside the chain.

Parameters:
- NDIG, 4, number of BCD digits in the chain (2..8).
- AUTO_STOP, 1, 1 = enter DONE at terminal count; 0 = keep counting and let the chain wrap.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle timebase enable (e.g. 100 Hz)
- btn_ss  in  1  start/stop button, debounced level
- btn_clr  in  1  clear button, debounced level
- btn_lap  in  1  lap button, debounced level
- dir_sel  in  1  requested direction, 1 = up, 0 = down
- q_flat  in  4*NDIG  current digit values, digit 0 in bits [3:0]
- cnt_en  out  1  advance the chain by one
- cnt_up  out  1  latched direction to the chain
- cnt_clr  out  1  one-cycle synchronous clear of all digits to 0
- cnt_load  out  1  one-cycle load of the preset value into the chain
- running  out  1  state == RUN
- done  out  1  state == DONE
- disp_hold  out  1  display freezes its shown value (lap)

Behaviour:
- Reset:
  - state = IDLE; cnt_up = 1.
  - cnt_en, cnt_clr, cnt_load, running, done and disp_hold all 0.
  - Button edge registers are cleared.
  - rst has priority over every other input in the same cycle.
- Button edges:
  - Each button goes through a rising-edge detector: ev = btn & ~btn_q, where btn_q is the button registered on clk.
  - An event acts on the next clock edge; a held button produces exactly one event.
- Event priority in the same cycle: clr > ss > lap.
- Terminal count (term):
  - When cnt_up = 1: every digit equals DIG_MAX[i].
  - When cnt_up = 0: every digit equals 0.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE:
    - clr_ev: cnt_clr = 1 if dir_sel = 1, otherwise cnt_load = 1 (one cycle). Stay in IDLE.
    - ss_ev: go to RUN.
    - cnt_up follows dir_sel every cycle while in IDLE.
  - RUN:
    - cnt_en = tick & ~(term & AUTO_STOP), combinational from registered state.
    - tick & term & AUTO_STOP: go to DONE next cycle, with no enable pulse issued.
    - ss_ev: go to PAUSE.
    - clr_ev: cnt_clr or cnt_load as in IDLE, then go to IDLE.
    - A tick and ss_ev in the same cycle: the enable is still issued (the count advances) and the state goes to PAUSE.
  - PAUSE:
    - cnt_en = 0.
    - ss_ev: go to RUN.
    - clr_ev: clear or load, then go to IDLE.
    - cnt_up follows dir_sel every cycle while in PAUSE.
  - DONE:
    - cnt_en = 0; done = 1.
    - ss_ev is ignored.
    - clr_ev: clear or load, then go to IDLE.
- Direction: cnt_up is frozen in RUN and DONE; a dir_sel change there has no effect.
- The cnt_clr and cnt_load pulses are registered and last exactly one cycle.
- Latency: button edge to state change is 2 clk (edge register, then state register).
- Reset mid-run: the chain is not cleared by rst itself. After reset, clr_ev is required to zero or preset the chain.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - lap_ev in RUN toggles disp_hold; the counting itself continues.
  - Any clr_ev forces disp_hold = 0.
  - lap_ev outside RUN is ignored.
- Undefined:
  - disp_hold is tied to 0.
  - btn_lap is unused and no lap edge register is built.

Decomposition:
- Package stopwatch_pkg:
  - typedef enum logic [1:0] sw_state_t {IDLE, RUN, PAUSE, DONE}.
  - typedef logic [3:0] bcd_t.
  - Constant array DIG_MAX (per-digit max, e.g. 9,9,9,5,9,5) and constant array DIG_PRESET (countdown load value).
- Sub-module edge_det: parameterised rising-edge detector with a sync reset, instantiated once per button.

Test Plan:
- Counting up:
  - ss pulse, then 5 ticks → cnt_en asserted on exactly 5 cycles; running = 1.
  - Second ss pulse → PAUSE; further ticks give cnt_en = 0.
- Terminal stop, up (AUTO_STOP = 1): q_flat = all DIG_MAX while in RUN, then tick → cnt_en = 0 that cycle; done = 1 on the next cycle; ss ignored afterwards.
- Countdown: dir_sel = 0 in IDLE, clr → cnt_load pulses for 1 cycle. Then start with q_flat = 0x0001 and one tick → cnt_en = 1. Then drive q_flat = 0, next tick → DONE.
- Simultaneous events:
  - clr and ss edges in the same cycle while in RUN → IDLE, cnt_clr = 1 for one cycle, no PAUSE.
  - tick and ss together → one cnt_en pulse, then PAUSE.
- Reset: rst asserted mid-RUN with disp_hold = 1 → next cycle state = IDLE, all outputs 0, cnt_up = 1; a button held through reset release generates no event.
- Lap (STOPWATCH_LAP_EN defined): lap in RUN → disp_hold = 1 while cnt_en keeps pulsing on ticks; lap again → disp_hold = 0. With the macro undefined, disp_hold stays 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and per-digit constants for the stopwatch control slice.
package stopwatch_pkg;

  localparam int unsigned MAX_DIG = 8;
  localparam int unsigned BCD_W   = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_t;

  // Digit 0 is hundredths: 99:59:59.99 style maximum, preset of 10:00.00 for countdown
  localparam bcd_t DIG_MAX [MAX_DIG] = '{
    4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9
  };

  localparam bcd_t DIG_PRESET [MAX_DIG] = '{
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0
  };

endpackage

// File: rtl/stopwatch_ctrl_edge_det.sv
// Registered rising-edge detector with synchronous reset, one bit per button.
module edge_det #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_btn,
  output logic [W-1:0] o_ev
);

  logic [W-1:0] r_btn_q;
  logic [W-1:0] r_ev;

  // The delayed copy tracks the button even in reset, so a level held
  // across reset release is not mistaken for a fresh press.
  always_ff @(posedge clk) begin
    r_btn_q <= i_btn;
    if (rst) begin
      r_ev <= '0;
    end else begin
      r_ev <= i_btn & ~r_btn_q;
    end
  end

  assign o_ev = r_ev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Control FSM for the cascaded BCD stopwatch counter chain.
// Optional lap/display-hold support is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned NDIG      = 4,
  parameter int unsigned AUTO_STOP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            btn_ss,
  input  logic            btn_clr,
  input  logic            btn_lap,
  input  logic            dir_sel,
  input  logic [4*NDIG-1:0] q_flat,
  output logic            cnt_en,
  output logic            cnt_up,
  output logic            cnt_clr,
  output logic            cnt_load,
  output logic            running,
  output logic            done,
  output logic            disp_hold
);

  localparam logic L_AUTO = (AUTO_STOP != 0);

  sw_state_t r_state, w_state_nxt;
  logic      r_cnt_up, w_up_nxt;
  logic      r_cnt_clr, w_clr_nxt;
  logic      r_cnt_load, w_load_nxt;
  logic      r_running, r_done;
  logic      w_ss_ev, w_clr_ev;
  logic      w_all_max, w_all_zero, w_term;
  logic [NDIG-1:0] w_dig_max;

  edge_det #(.W(1)) u_ss_edge (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_ss),
    .o_ev  (w_ss_ev)
  );

  edge_det #(.W(1)) u_clr_edge (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_clr),
    .o_ev  (w_clr_ev)
  );

  // Terminal count: all digits at their max going up, all zero going down
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign w_dig_max[g] = (q_flat[4*g +: 4] == DIG_MAX[g]);
  end

  assign w_all_max  = &w_dig_max;
  assign w_all_zero = ~|q_flat;
  assign w_term     = r_cnt_up ? w_all_max : w_all_zero;

  assign cnt_en = (r_state == RUN) & tick & ~(w_term & L_AUTO);

  always_comb begin
    w_state_nxt = r_state;
    w_up_nxt    = r_cnt_up;
    w_clr_nxt   = 1'b0;
    w_load_nxt  = 1'b0;

    if (w_clr_ev) begin
      w_clr_nxt   = dir_sel;
      w_load_nxt  = ~dir_sel;
      w_state_nxt = IDLE;
    end

    case (r_state)
      IDLE: begin
        w_up_nxt = dir_sel;
        if (!w_clr_ev && w_ss_ev) w_state_nxt = RUN;
      end
      RUN: begin
        if (!w_clr_ev) begin
          if (w_ss_ev)                        w_state_nxt = PAUSE;
          else if (tick && w_term && L_AUTO)  w_state_nxt = DONE;
        end
      end
      PAUSE: begin
        w_up_nxt = dir_sel;
        if (!w_clr_ev && w_ss_ev) w_state_nxt = RUN;
      end
      DONE: begin
        w_state_nxt = w_clr_ev ? IDLE : DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt_up   <= 1'b1;
      r_cnt_clr  <= 1'b0;
      r_cnt_load <= 1'b0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt_up   <= w_up_nxt;
      r_cnt_clr  <= w_clr_nxt;
      r_cnt_load <= w_load_nxt;
      r_running  <= (w_state_nxt == RUN);
      r_done     <= (w_state_nxt == DONE);
    end
  end

  assign cnt_up   = r_cnt_up;
  assign cnt_clr  = r_cnt_clr;
  assign cnt_load = r_cnt_load;
  assign running  = r_running;
  assign done     = r_done;

`ifdef STOPWATCH_LAP_EN
  logic w_lap_ev;
  logic r_disp_hold, w_hold_nxt;

  edge_det #(.W(1)) u_lap_edge (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_lap),
    .o_ev  (w_lap_ev)
  );

  // Lap only acts in RUN and loses to a same-cycle clear or start/stop
  always_comb begin
    w_hold_nxt = r_disp_hold;
    if (w_clr_ev)
      w_hold_nxt = 1'b0;
    else if ((r_state == RUN) && !w_ss_ev && w_lap_ev)
      w_hold_nxt = ~r_disp_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) r_disp_hold <= 1'b0;
    else     r_disp_hold <= w_hold_nxt;
  end

  assign disp_hold = r_disp_hold;
`else
  logic w_unused_lap;
  assign w_unused_lap = btn_lap;
  assign disp_hold    = 1'b0;
`endif

endmodule
